// File: rtl/network_udiv_seq_32u_16u_if.sv
`default_nettype none
// ============================================================================
// Module   : network_udiv_seq_32u_16u_if
// Brief    : Operand/result valid-ready bundle for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface network_udiv_seq_32u_16u_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/network_udiv_seq_32u_16u.sv
`default_nettype none
// ============================================================================
// Module   : network_udiv_seq_32u_16u
// Brief    : Restoring shift-subtract unsigned divider, one quotient bit/clock.
// Revision : 1.0 - initial release
// ============================================================================
module network_udiv_seq_32u_16u #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  wire logic                        ap_clk,
    input  wire logic                        ap_rst_n,
    network_udiv_seq_32u_16u_if.slave        bus
);
    localparam int c_CNT_W = $clog2(DIVIDEND_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [DIVIDEND_WIDTH-1:0] r_dvd;
    logic [DIVISOR_WIDTH-1:0]  r_dvs;
    logic [DIVISOR_WIDTH:0]    r_prem;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [DIVIDEND_WIDTH-1:0] r_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_remainder;
    logic                      r_div_by_zero;

    // The dividend register doubles as the quotient: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    logic [DIVISOR_WIDTH+1:0]  w_shift;
    logic [DIVISOR_WIDTH+1:0]  w_diff;
    logic                      w_ge;
    logic [DIVISOR_WIDTH:0]    w_prem_nxt;
    logic [DIVIDEND_WIDTH-1:0] w_dvd_nxt;

    assign w_shift    = {r_prem, r_dvd[DIVIDEND_WIDTH-1]};
    assign w_diff     = w_shift - {2'b00, r_dvs};
    assign w_ge       = ~w_diff[DIVISOR_WIDTH+1];
    assign w_prem_nxt = w_ge ? w_diff[DIVISOR_WIDTH:0] : w_shift[DIVISOR_WIDTH:0];
    assign w_dvd_nxt  = {r_dvd[DIVIDEND_WIDTH-2:0], w_ge};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_dvd         <= '0;
            r_dvs         <= '0;
            r_prem        <= '0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_state       <= S_DONE;
                            r_out_valid   <= 1'b1;
                            r_quotient    <= '1;
                            r_remainder   <= bus.dividend[DIVISOR_WIDTH-1:0];
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                            r_dvd   <= bus.dividend;
                            r_dvs   <= bus.divisor;
                            r_prem  <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_dvd  <= w_dvd_nxt;
                    r_prem <= w_prem_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state       <= S_DONE;
                        r_out_valid   <= 1'b1;
                        r_quotient    <= w_dvd_nxt;
                        r_remainder   <= w_prem_nxt[DIVISOR_WIDTH-1:0];
                        r_div_by_zero <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_network_udiv_seq_32u_16u.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_udiv_seq_32u_16u
// Brief    : Directed self-checking bench for the sequential unsigned divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_network_udiv_seq_32u_16u;
    logic ap_clk = 1'b0;
    logic ap_rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 ap_clk = ~ap_clk;

    network_udiv_seq_32u_16u_if #(.DIVIDEND_WIDTH(32), .DIVISOR_WIDTH(16)) bus ();

    network_udiv_seq_32u_16u #(
        .DIVIDEND_WIDTH (32),
        .DIVISOR_WIDTH  (16)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int c = 0;
        while (!bus.in_ready && c < 100) begin
            @(negedge ap_clk);
            c++;
        end
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Returns at the negedge following the accept edge, with operands scrambled.
    task automatic send(input string tag, input logic [31:0] dvd, input logic [15:0] dvs);
        wait_ready(tag);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        bus.in_valid = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 16'h0BAD;
    endtask

    // lat counts edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge ap_clk);
            lat++;
        end
    endtask

    task automatic check_div(input string tag, input logic [31:0] q, input logic [15:0] r);
        int lat;
        wait_valid(lat);
        chk({tag, "_lat"}, lat, 32'd32);
        chk({tag, "_q"}, bus.quotient, q);
        chk({tag, "_r"}, {16'd0, bus.remainder}, {16'd0, r});
        chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_iready_rise"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    logic [31:0] bb_dvd [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'd5};
    logic [15:0] bb_dvs [3] = '{16'd1, 16'hFFFF, 16'd9};
    logic [31:0] bb_q   [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [15:0] bb_r   [3] = '{16'd0, 16'd1, 16'd5};

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] rd;
        logic [15:0] rv;

        ap_rst_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", {16'd0, bus.remainder}, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        ap_rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(negedge ap_clk);
        chk("rel_in_ready_high", {31'd0, bus.in_ready}, 32'd1);

        // 100 / 7 with out_ready held high: one-cycle result pulse
        bus.out_ready = 1'b1;
        send("d100", 32'd100, 16'd7);
        check_div("d100", 32'd14, 16'd2);
        @(negedge ap_clk);
        chk("d100_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        chk("d100_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Back-to-back with in_valid held high
        bus.dividend = bb_dvd[0];
        bus.divisor  = bb_dvs[0];
        bus.in_valid = 1'b1;
        wait_ready("b2b");
        for (int i = 0; i < 3; i++) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (i < 2) begin
                bus.dividend = bb_dvd[i+1];
                bus.divisor  = bb_dvs[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            check_div($sformatf("b2b%0d", i), bb_q[i], bb_r[i]);
            @(posedge ap_clk);
            @(negedge ap_clk);
            chk($sformatf("b2b%0d_ovalid_drop", i), {31'd0, bus.out_valid}, 32'd0);
            chk($sformatf("b2b%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
        end
        bus.out_ready = 1'b0;

        // Divide by zero, then a normal division must clear the flag
        send("dz", 32'd1234, 16'd0);
        wait_valid(lat);
        chk("dz_lat_le1", {31'd0, (lat <= 1)}, 32'd1);
        chk("dz_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("dz_q", bus.quotient, 32'hFFFF_FFFF);
        chk("dz_r", {16'd0, bus.remainder}, 32'h0000_04D2);
        chk("dz_dbz", {31'd0, bus.div_by_zero}, 32'd1);
        consume("dz");
        send("after_dz", 32'd6, 16'd3);
        check_div("after_dz", 32'd2, 16'd0);
        consume("after_dz");

        // Back-pressure with toggling ignored operands
        send("bp", 32'd1000, 16'd3);
        check_div("bp", 32'd333, 16'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.dividend = 32'd50 + 32'(i);
            bus.divisor  = 16'd5;
            @(posedge ap_clk);
            @(negedge ap_clk);
            chk($sformatf("bp_hold%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_q", i), bus.quotient, 32'd333);
            chk($sformatf("bp_hold%0d_r", i), {16'd0, bus.remainder}, 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        consume("bp");
        seen = 1'b0;
        repeat (40) begin
            @(negedge ap_clk);
            seen = seen | bus.out_valid;
        end
        chk("bp_no_extra_result", {31'd0, seen}, 32'd0);

        // Reset in the middle of BUSY
        send("rst_mid", 32'd5000, 16'd7);
        repeat (15) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_q", bus.quotient, 32'd0);
        chk("midrst_r", {16'd0, bus.remainder}, 32'd0);
        chk("midrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("midrst_rel_low", {31'd0, bus.in_ready}, 32'd0);
        @(negedge ap_clk);
        chk("midrst_rel_high", {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge ap_clk);
            seen = seen | bus.out_valid;
        end
        chk("midrst_no_partial", {31'd0, seen}, 32'd0);
        send("d77", 32'd77, 16'd11);
        check_div("d77", 32'd7, 16'd0);
        consume("d77");

        // Random pairs with forced corner categories against the native operators
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case (i % 4)
                0: begin rv = 16'd1;    rd = $urandom; end
                1: begin rv = 16'hFFFF; rd = $urandom; end
                2: begin
                    rv = 16'($urandom_range(1, 65535));
                    rd = 32'($urandom_range(0, 32'(rv) - 1));
                end
                default: begin
                    rv = 16'($urandom_range(1, 65535));
                    rd = $urandom;
                end
            endcase
            send($sformatf("rnd%0d", i), rd, rv);
            wait_valid(lat);
            chk($sformatf("rnd%0d_lat", i), lat, 32'd32);
            chk($sformatf("rnd%0d_q", i), bus.quotient, rd / {16'd0, rv});
            chk($sformatf("rnd%0d_r", i), {16'd0, bus.remainder}, rd % {16'd0, rv});
        end
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
